// File: rtl/pipeline_control_idt_write.sv
// Streams the 64-entry interrupt configuration table back to the in-memory IDT
// through the shared load/store port, one word store per entry.
//
// state   | meaning
// IDLE    | waiting for iWR_START
// FETCH   | one-cycle ICT read request for entry b_wr_cnt
// CAPTURE | waiting for ICT read data
// STORE   | store request on the load/store port until accepted
// DRAIN   | all stores issued, waiting for the remaining acks
module pipeline_control_idt_write (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iRESET_SYNC,
    input  logic [31:0] iSYSREG_IDTR,
    input  logic        iWR_START,
    output logic        oWR_FINISH,
    output logic        oICT_RD_REQ,
    output logic [5:0]  oICT_RD_ENTRY,
    input  logic        iICT_RD_VALID,
    input  logic        iICT_RD_MASK,
    input  logic        iICT_RD_VALID_FLAG,
    input  logic [1:0]  iICT_RD_LEVEL,
    output logic        oLDST_USE,
    output logic        oLDST_REQ,
    input  logic        iLDST_BUSY,
    output logic [1:0]  oLDST_ORDER,
    output logic        oLDST_RW,
    output logic [13:0] oLDST_ASID,
    output logic [1:0]  oLDST_MMUMOD,
    output logic [31:0] oLDST_PDT,
    output logic [31:0] oLDST_ADDR,
    output logic [31:0] oLDST_DATA,
    input  logic        iLDST_REQ
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_STORE,
        ST_DRAIN
    } state_t;

    state_t      b_state;
    state_t      next_state;
    logic [31:0] b_base;
    logic [6:0]  b_wr_cnt;
    logic [6:0]  b_ack_cnt;
    logic [31:0] b_data;
    logic        b_finish;

    logic        store_accept;
    logic        ack_inc;
    logic [6:0]  ack_next;
    logic        ack_done;

    assign store_accept = (b_state == ST_STORE) && !iLDST_BUSY;
    // Acks saturate at 64; extra ones after the table is done change nothing.
    assign ack_inc  = iLDST_REQ && (b_state != ST_IDLE) && (b_ack_cnt != 7'd64);
    assign ack_next = b_ack_cnt + {6'h0, ack_inc};
    assign ack_done = (b_state == ST_DRAIN) && (ack_next == 7'd64);

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            b_state <= ST_IDLE;
        end else if (iRESET_SYNC) begin
            b_state <= ST_IDLE;
        end else begin
            b_state <= next_state;
        end
    end

    always_comb begin
        next_state = b_state;
        case (b_state)
            ST_IDLE:    if (iWR_START) next_state = ST_FETCH;
            ST_FETCH:   next_state = ST_CAPTURE;
            ST_CAPTURE: if (iICT_RD_VALID) next_state = ST_STORE;
            ST_STORE: begin
                if (store_accept) begin
                    next_state = (b_wr_cnt == 7'd63) ? ST_DRAIN : ST_FETCH;
                end
            end
            ST_DRAIN:   if (ack_done) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            b_base    <= 32'h0;
            b_wr_cnt  <= 7'h0;
            b_ack_cnt <= 7'h0;
            b_data    <= 32'h0;
            b_finish  <= 1'b0;
        end else if (iRESET_SYNC) begin
            b_base    <= 32'h0;
            b_wr_cnt  <= 7'h0;
            b_ack_cnt <= 7'h0;
            b_data    <= 32'h0;
            b_finish  <= 1'b0;
        end else begin
            b_finish <= ack_done;
            if (b_state == ST_IDLE) begin
                if (iWR_START) begin
                    b_base    <= iSYSREG_IDTR;
                    b_wr_cnt  <= 7'h0;
                    b_ack_cnt <= 7'h0;
                end
            end else begin
                b_ack_cnt <= ack_next;
                if (store_accept) begin
                    b_wr_cnt <= b_wr_cnt + 7'd1;
                end
            end
            if ((b_state == ST_CAPTURE) && iICT_RD_VALID) begin
                b_data <= {14'h0, iICT_RD_LEVEL, 14'h0, iICT_RD_MASK, iICT_RD_VALID_FLAG};
            end
        end
    end

    assign oWR_FINISH    = b_finish;
    assign oICT_RD_REQ   = (b_state == ST_FETCH);
    assign oICT_RD_ENTRY = b_wr_cnt[5:0];

    assign oLDST_USE     = (b_state != ST_IDLE);
    assign oLDST_REQ     = store_accept;
    assign oLDST_ADDR    = b_base + {22'h0, b_wr_cnt, 3'h0};
    assign oLDST_DATA    = b_data;
    assign oLDST_ORDER   = 2'h2;
    assign oLDST_RW      = 1'b1;
    assign oLDST_ASID    = 14'h0;
    assign oLDST_MMUMOD  = 2'h0;
    assign oLDST_PDT     = 32'h0;

endmodule

// File: tb/tb_pipeline_control_idt_write.sv
// Directed bench for pipeline_control_idt_write: an ICT responder and a load/store
// ack model drive the block while every store is compared against hand-derived values.
module tb_pipeline_control_idt_write;
    logic        iCLOCK = 1'b0;
    logic        inRESET;
    logic        iRESET_SYNC;
    logic [31:0] iSYSREG_IDTR;
    logic        iWR_START;
    logic        oWR_FINISH;
    logic        oICT_RD_REQ;
    logic [5:0]  oICT_RD_ENTRY;
    logic        iICT_RD_VALID;
    logic        iICT_RD_MASK;
    logic        iICT_RD_VALID_FLAG;
    logic [1:0]  iICT_RD_LEVEL;
    logic        oLDST_USE;
    logic        oLDST_REQ;
    logic        iLDST_BUSY;
    logic [1:0]  oLDST_ORDER;
    logic        oLDST_RW;
    logic [13:0] oLDST_ASID;
    logic [1:0]  oLDST_MMUMOD;
    logic [31:0] oLDST_PDT;
    logic [31:0] oLDST_ADDR;
    logic [31:0] oLDST_DATA;
    logic        iLDST_REQ;

    pipeline_control_idt_write dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
        .iSYSREG_IDTR(iSYSREG_IDTR), .iWR_START(iWR_START), .oWR_FINISH(oWR_FINISH),
        .oICT_RD_REQ(oICT_RD_REQ), .oICT_RD_ENTRY(oICT_RD_ENTRY),
        .iICT_RD_VALID(iICT_RD_VALID), .iICT_RD_MASK(iICT_RD_MASK),
        .iICT_RD_VALID_FLAG(iICT_RD_VALID_FLAG), .iICT_RD_LEVEL(iICT_RD_LEVEL),
        .oLDST_USE(oLDST_USE), .oLDST_REQ(oLDST_REQ), .iLDST_BUSY(iLDST_BUSY),
        .oLDST_ORDER(oLDST_ORDER), .oLDST_RW(oLDST_RW), .oLDST_ASID(oLDST_ASID),
        .oLDST_MMUMOD(oLDST_MMUMOD), .oLDST_PDT(oLDST_PDT), .oLDST_ADDR(oLDST_ADDR),
        .oLDST_DATA(oLDST_DATA), .iLDST_REQ(iLDST_REQ)
    );

    always #5 iCLOCK = ~iCLOCK;

    int n_checks = 0;
    int n_fails  = 0;

    // per-run observations
    int          stores, first_req_iter, last_store_iter, finish_cnt, finish_iter;
    int          ack64_iter, err_addr, err_data, err_entry, rdreq_cnt, rdreq_dbl;
    int          req_in_capture, busy_ok, drain_bad, start_use, start_rdreq;
    logic [31:0] addr1, data0, data63;
    logic        end_use;
    bit          aborted;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input int n);
        return {14'h0, n[1:0], 14'h0, n[0], 1'b1};
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_ctrl"},
                  {54'h0, oWR_FINISH, oICT_RD_REQ, oICT_RD_ENTRY, oLDST_USE, oLDST_REQ}, 64'h0);
        check_val({tag, "_addr"}, {32'h0, oLDST_ADDR}, 64'h0);
        check_val({tag, "_data"}, {32'h0, oLDST_DATA}, 64'h0);
        check_val({tag, "_const"},
                  {13'h0, oLDST_ORDER, oLDST_RW, oLDST_ASID, oLDST_MMUMOD, oLDST_PDT},
                  {13'h0, 2'h2, 1'b1, 14'h0, 2'h0, 32'h0});
    endtask

    // Iteration 0 drives the start pulse; iteration k samples the cycle after clock edge k.
    task automatic run_seq(input logic [31:0] base, input int ict_delay, input int busy_entry,
                           input int busy_len, input bit delay_ack, input int mid_start,
                           input int abort_at);
        int          iter, ict_wait, busy_left, ack_pending, acks_sent, tail;
        bit          ict_pend, cap, busy_now, prev_rdreq;
        logic [5:0]  ict_idx;
        logic [31:0] exp_addr;
        stores = 0; first_req_iter = -1; last_store_iter = -1; finish_cnt = 0; finish_iter = -1;
        ack64_iter = -1; err_addr = 0; err_data = 0; err_entry = 0; rdreq_cnt = 0; rdreq_dbl = 0;
        req_in_capture = 0; busy_ok = 0; drain_bad = 0; start_use = 0; start_rdreq = 0;
        addr1 = 32'hdead_beef; data0 = 32'h0; data63 = 32'h0; end_use = 1'b1; aborted = 1'b0;
        ict_pend = 1'b0; ict_wait = 0; ict_idx = 6'h0; busy_left = 0; ack_pending = 0;
        acks_sent = 0; tail = 0; prev_rdreq = 1'b0;

        @(posedge iCLOCK); #1;
        iSYSREG_IDTR = base;
        iWR_START    = 1'b1;
        for (iter = 1; iter < 3000; iter++) begin
            @(posedge iCLOCK); #1;
            iWR_START          = (iter == mid_start);
            iICT_RD_VALID      = 1'b0;
            iICT_RD_MASK       = 1'b0;
            iICT_RD_VALID_FLAG = 1'b0;
            iICT_RD_LEVEL      = 2'h0;
            cap = ict_pend;
            if (ict_pend) begin
                if (ict_wait == 0) begin
                    iICT_RD_VALID      = 1'b1;
                    iICT_RD_MASK       = ict_idx[0];
                    iICT_RD_VALID_FLAG = 1'b1;
                    iICT_RD_LEVEL      = ict_idx[1:0];
                    ict_pend = 1'b0;
                end else begin
                    ict_wait--;
                end
            end
            busy_now   = (busy_left > 0);
            iLDST_BUSY = busy_now;
            iLDST_REQ  = (ack_pending > 0);
            if (ack_pending > 0) begin
                ack_pending--;
                acks_sent++;
                if (acks_sent == 64) ack64_iter = iter;
            end
            iRESET_SYNC = (abort_at >= 0) && (stores == abort_at) && cap;
            #1;
            if (iRESET_SYNC) begin
                aborted = 1'b1;
                break;
            end
            if (iter == 1) begin
                start_use   = oLDST_USE;
                start_rdreq = oICT_RD_REQ;
            end
            if (oWR_FINISH) begin
                finish_cnt++;
                finish_iter = iter;
            end
            if (oICT_RD_REQ) begin
                rdreq_cnt++;
                if (prev_rdreq) rdreq_dbl++;
                if (oICT_RD_ENTRY != stores[5:0]) err_entry++;
                ict_pend = 1'b1;
                ict_idx  = oICT_RD_ENTRY;
                ict_wait = ict_delay;
            end
            prev_rdreq = oICT_RD_REQ;
            if (cap && oLDST_REQ) req_in_capture++;
            if (iICT_RD_VALID && (ict_idx == busy_entry[5:0]) && (busy_entry >= 0))
                busy_left = busy_len;
            if (busy_now) begin
                if (!oLDST_REQ && oLDST_USE && (oLDST_ADDR == base + 32'(busy_entry * 8)))
                    busy_ok++;
                busy_left--;
            end
            if ((stores == 64) && (last_store_iter < iter) &&
                ((acks_sent < 64) || (ack64_iter == iter)) && (!oLDST_USE || oWR_FINISH))
                drain_bad++;
            if (oLDST_REQ) begin
                exp_addr = base + 32'(stores * 8);
                if (oLDST_ADDR !== exp_addr) err_addr++;
                if (oLDST_DATA !== exp_data(stores)) err_data++;
                if (stores == 0) begin
                    first_req_iter = iter;
                    data0 = oLDST_DATA;
                end
                if (stores == 1)  addr1  = oLDST_ADDR;
                if (stores == 63) data63 = oLDST_DATA;
                last_store_iter = iter;
                stores++;
                if (!delay_ack) ack_pending++;
                else if (stores == 64) ack_pending = 66;
            end
            end_use = oLDST_USE;
            if (finish_cnt > 0) begin
                tail++;
                if ((tail >= 3) && (ack_pending == 0)) break;
            end
        end
        if (!aborted) begin
            iLDST_REQ   = 1'b0;
            iLDST_BUSY  = 1'b0;
            iWR_START   = 1'b0;
        end
    endtask

    initial begin
        inRESET = 1'b0; iRESET_SYNC = 1'b0; iSYSREG_IDTR = 32'h0; iWR_START = 1'b0;
        iICT_RD_VALID = 1'b0; iICT_RD_MASK = 1'b0; iICT_RD_VALID_FLAG = 1'b0;
        iICT_RD_LEVEL = 2'h0; iLDST_BUSY = 1'b0; iLDST_REQ = 1'b0;
        repeat (2) @(posedge iCLOCK);
        #1;
        check_idle_outputs("reset");
        inRESET = 1'b1;

        // nominal
        run_seq(32'h0001_0000, 0, -1, 0, 1'b0, -1, -1);
        check_val("nom_use_at_start", 64'(start_use), 64'd1);
        check_val("nom_rdreq_at_start", 64'(start_rdreq), 64'd1);
        check_val("nom_stores", 64'(stores), 64'd64);
        check_val("nom_addr_errs", 64'(err_addr), 64'd0);
        check_val("nom_data_errs", 64'(err_data), 64'd0);
        check_val("nom_entry_errs", 64'(err_entry), 64'd0);
        check_val("nom_first_store", 64'(first_req_iter), 64'd3);
        check_val("nom_last_store", 64'(last_store_iter), 64'd192);
        check_val("nom_data0", {32'h0, data0}, 64'h0000_0001);
        check_val("nom_data63", {32'h0, data63}, 64'h0003_0003);
        check_val("nom_finish_cnt", 64'(finish_cnt), 64'd1);
        check_val("nom_finish_iter", 64'(finish_iter), 64'd194);
        check_val("nom_finish_after_ack", 64'(finish_iter), 64'(ack64_iter + 1));
        check_val("nom_use_end", {63'h0, end_use}, 64'd0);
        check_val("nom_drain", 64'(drain_bad), 64'd0);

        // busy stall on entry 10
        run_seq(32'h0001_0000, 0, 10, 5, 1'b0, -1, -1);
        check_val("busy_held_cycles", 64'(busy_ok), 64'd5);
        check_val("busy_stores", 64'(stores), 64'd64);
        check_val("busy_addr_errs", 64'(err_addr), 64'd0);
        check_val("busy_data_errs", 64'(err_data), 64'd0);
        check_val("busy_last_store", 64'(last_store_iter), 64'd197);
        check_val("busy_finish_cnt", 64'(finish_cnt), 64'd1);

        // slow ICT
        run_seq(32'h0002_0000, 4, -1, 0, 1'b0, -1, -1);
        check_val("slow_rdreq_cnt", 64'(rdreq_cnt), 64'd64);
        check_val("slow_rdreq_pulse", 64'(rdreq_dbl), 64'd0);
        check_val("slow_req_in_capture", 64'(req_in_capture), 64'd0);
        check_val("slow_data_errs", 64'(err_data), 64'd0);
        check_val("slow_first_store", 64'(first_req_iter), 64'd7);
        check_val("slow_finish_cnt", 64'(finish_cnt), 64'd1);

        // delayed acks, two extras after the 64th
        run_seq(32'h0001_0000, 0, -1, 0, 1'b1, -1, -1);
        check_val("dack_ack64_iter", 64'(ack64_iter), 64'd256);
        check_val("dack_drain_held", 64'(drain_bad), 64'd0);
        check_val("dack_finish_iter", 64'(finish_iter), 64'd257);
        check_val("dack_finish_cnt", 64'(finish_cnt), 64'd1);
        check_val("dack_use_end", {63'h0, end_use}, 64'd0);

        // address wrap plus ignored mid-sequence start
        run_seq(32'hFFFF_FFF8, 0, -1, 0, 1'b0, 50, -1);
        check_val("wrap_addr1", {32'h0, addr1}, 64'h0);
        check_val("wrap_addr_errs", 64'(err_addr), 64'd0);
        check_val("wrap_stores", 64'(stores), 64'd64);
        check_val("wrap_finish_iter", 64'(finish_iter), 64'd194);

        // abort at entry 30
        run_seq(32'h0001_0000, 0, -1, 0, 1'b0, -1, 30);
        check_val("abort_reached", {63'h0, aborted}, 64'd1);
        check_val("abort_stores", 64'(stores), 64'd30);
        @(posedge iCLOCK); #1;
        iRESET_SYNC = 1'b0; iLDST_REQ = 1'b0; iICT_RD_VALID = 1'b0; iLDST_BUSY = 1'b0;
        iWR_START = 1'b0;
        #1;
        check_idle_outputs("abort");
        finish_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge iCLOCK); #2;
            if (oWR_FINISH || oLDST_USE) finish_cnt++;
        end
        check_val("abort_quiet", 64'(finish_cnt), 64'd0);

        run_seq(32'h0003_0000, 0, -1, 0, 1'b0, -1, -1);
        check_val("restart_first_store", 64'(first_req_iter), 64'd3);
        check_val("restart_data0", {32'h0, data0}, 64'h0000_0001);
        check_val("restart_addr_errs", 64'(err_addr), 64'd0);
        check_val("restart_stores", 64'(stores), 64'd64);
        check_val("restart_finish_cnt", 64'(finish_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
